uart_byte_rx: RTL and testbench

- Serial receive front end that produces the byte presented on the 8-bit `din` of the byte-transform stage.
- Deserialises 8N1 asynchronous serial into parallel bytes.
- Emits a one-cycle `valid` strobe with each received byte and holds the byte stable until the next one.
- Flags frames whose stop bit is bad; those frames are dropped.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_byte_rx.sv | 120 ++++++++++++
 tb/tb_uart_byte_rx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // One spare bit above clog2 keeps CLKS_PER_BIT-1 representable for any legal value.
    function automatic int baud_width(input int cpb);
        return $clog2(cpb) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the raw serial line; resets to 1 so the line reads idle.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic rxd,
    output logic rxs
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], rxd};
        end
    end

    assign rxs = sync_q[STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 serial receiver: mid-bit sampling, one-cycle valid per good byte, frame_err on bad stop bit.
//
// state | meaning
// IDLE  | line idle, waiting for rxs low
// START | timing to start-bit middle, rejects glitches
// DATA  | sampling eight data bits LSB first
// STOP  | sampling stop bit, publishing or dropping the byte
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int BW = baud_width(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST    = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);

    logic          rxs;
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .rxd   (rxd),
        .rxs   (rxs)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = (baud_q == LAST) ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!rxs) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == HALF_M1) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                // Counter wraps to 0 here, so each bit is sampled one full period later.
                if (baud_q == LAST) begin
                    shift_d[bit_q] = rxs;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_q == LAST) begin
                    state_d = IDLE;
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at CLKS_PER_BIT=8 and CLKS_PER_BIT=5.
module tb_uart_byte_rx;

    logic       clock;
    logic       reset;
    logic       rxd8, rxd5;
    logic [7:0] data8, data5;
    logic       valid8, valid5;
    logic       ferr8, ferr5;
    logic       busy8, busy5;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    int v8_cnt = 0, v8_cyc = 0, v8_prev = 0, f8_cnt = 0, b8_cnt = 0;
    int v5_cnt = 0, v5_cyc = 0, f5_cnt = 0;
    int both_cnt = 0;

    uart_byte_rx #(.CLKS_PER_BIT(8), .SYNC_STAGES(2)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .rxd       (rxd8),
        .data      (data8),
        .valid     (valid8),
        .frame_err (ferr8),
        .busy      (busy8)
    );

    uart_byte_rx #(.CLKS_PER_BIT(5), .SYNC_STAGES(2)) dut5 (
        .clock     (clock),
        .reset     (reset),
        .rxd       (rxd5),
        .data      (data5),
        .valid     (valid5),
        .frame_err (ferr5),
        .busy      (busy5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (!reset) begin
            if (valid8) begin
                v8_cnt++;
                v8_prev = v8_cyc;
                v8_cyc  = cyc;
            end
            if (ferr8) f8_cnt++;
            if (busy8) b8_cnt++;
            if (valid5) begin
                v5_cnt++;
                v5_cyc = cyc;
            end
            if (ferr5) f5_cnt++;
            if ((valid8 && ferr8) || (valid5 && ferr5)) both_cnt++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Call at a negedge; leaves the stop-bit level on the line.
    task automatic send(input int sel, input logic [7:0] b, input logic stop_bit, output int fall);
        logic [9:0] frame;
        int cpb;
        frame = {stop_bit, b, 1'b0};
        cpb   = (sel == 0) ? 8 : 5;
        fall  = cyc;
        for (int i = 0; i < 10; i++) begin
            if (sel == 0) rxd8 = frame[i];
            else          rxd5 = frame[i];
            repeat (cpb) @(negedge clock);
        end
    endtask

    initial begin
        int f, f1, f2, sv, sf, sb;
        logic [7:0] b5a;

        reset = 1'b1;
        rxd8  = 1'b1;
        rxd5  = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_data8", data8, 8'h00);
        chk("rst_valid8", valid8, 0);
        chk("rst_ferr8", ferr8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_data5", data5, 8'h00);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Single good frame
        sv = v8_cnt; sf = f8_cnt;
        send(0, 8'hA5, 1'b1, f);
        repeat (20) @(negedge clock);
        chk("a5_count", v8_cnt - sv, 1);
        chk("a5_data", data8, 8'hA5);
        chk("a5_latency", v8_cyc - f, 79);
        chk("a5_ferr", f8_cnt - sf, 0);

        // Back-to-back frames with no idle gap
        sv = v8_cnt;
        send(0, 8'h00, 1'b1, f1);
        chk("b2b_data0", data8, 8'h00);
        send(0, 8'hFF, 1'b1, f2);
        repeat (20) @(negedge clock);
        chk("b2b_count", v8_cnt - sv, 2);
        chk("b2b_interval", v8_cyc - v8_prev, 80);
        chk("b2b_data1", data8, 8'hFF);
        chk("b2b_latency", v8_cyc - f2, 79);

        // Short glitch: false start
        sv = v8_cnt; sf = f8_cnt; sb = b8_cnt;
        rxd8 = 1'b0;
        repeat (2) @(negedge clock);
        rxd8 = 1'b1;
        repeat (20) @(negedge clock);
        chk("glitch_valid", v8_cnt - sv, 0);
        chk("glitch_ferr", f8_cnt - sf, 0);
        chk("glitch_busy_range", ((b8_cnt - sb) >= 1 && (b8_cnt - sb) <= 5) ? 1 : 0, 1);

        // Bad stop bit
        sv = v8_cnt; sf = f8_cnt;
        send(0, 8'h3C, 1'b0, f);
        rxd8 = 1'b1;
        repeat (20) @(negedge clock);
        chk("ferr_count", f8_cnt - sf, 1);
        chk("ferr_valid", v8_cnt - sv, 0);
        chk("ferr_data", data8, 8'hFF);

        // Reset during bit 4 of 8'h5A
        sv = v8_cnt;
        b5a = 8'h5A;
        rxd8 = 1'b0;
        repeat (8) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rxd8 = b5a[i];
            repeat (8) @(negedge clock);
        end
        rxd8 = b5a[4];
        repeat (3) @(negedge clock);
        chk("mid_busy_before", busy8, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_data", data8, 8'h00);
        rxd8 = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (100) @(negedge clock);
        chk("mid_no_valid", v8_cnt - sv, 0);
        chk("mid_data_kept", data8, 8'h00);
        send(0, 8'h81, 1'b1, f);
        repeat (20) @(negedge clock);
        chk("post_rst_count", v8_cnt - sv, 1);
        chk("post_rst_data", data8, 8'h81);

        // Odd bit period
        sv = v5_cnt; sf = f5_cnt;
        send(1, 8'hC3, 1'b1, f);
        repeat (20) @(negedge clock);
        chk("c3_count", v5_cnt - sv, 1);
        chk("c3_data", data5, 8'hC3);
        chk("c3_latency", v5_cyc - f, 50);
        chk("c3_ferr", f5_cnt - sf, 0);

        chk("never_both", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
